// File: rtl/rom_to_ram_scaler.sv
// ROM-to-framebuffer copy engine with power-of-two rescaling.
// Walks the destination image in raster order, issues one ROM read per
// cycle and writes each finished destination pixel to the framebuffer.
// Modes: 00 upscale, 01 decimate, 10 copy, 11 box-average downscale.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_RUN   | one ROM read per cycle, destination counters advancing
// S_DRAIN | last read issued, final write still in the ROM pipeline
// S_DONE  | one-cycle done pulse; a start here is accepted directly
module rom_to_ram_scaler #(
   parameter int SRC_W  = 160,
   parameter int SRC_H  = 120,
   parameter int FACTOR = 2,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 19
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [PIX_W-1:0]  rom_data,
   output logic [ADDR_W-1:0] ram_wraddr,
   output logic [PIX_W-1:0]  ram_data,
   output logic              ram_wren,
   output logic              busy,
   output logic              done,
   output logic [9:0]        dst_w,
   output logic [9:0]        dst_h
);

   localparam int L     = $clog2(FACTOR);
   localparam int ACC_W = PIX_W + 2*L;

   localparam logic [1:0] M_UP   = 2'b00;
   localparam logic [1:0] M_DEC  = 2'b01;
   localparam logic [1:0] M_COPY = 2'b10;
   localparam logic [1:0] M_AVG  = 2'b11;

   localparam logic [ADDR_W-1:0] W_UP = ADDR_W'(SRC_W*FACTOR);
   localparam logic [ADDR_W-1:0] H_UP = ADDR_W'(SRC_H*FACTOR);
   localparam logic [ADDR_W-1:0] W_DN = ADDR_W'(SRC_W/FACTOR);
   localparam logic [ADDR_W-1:0] H_DN = ADDR_W'(SRC_H/FACTOR);
   localparam logic [ADDR_W-1:0] W_CP = ADDR_W'(SRC_W);
   localparam logic [ADDR_W-1:0] H_CP = ADDR_W'(SRC_H);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            r_state, w_next;
   logic [1:0]        r_mode;
   logic [ADDR_W-1:0] r_dx, r_dy, r_didx, r_wraddr;
   logic [L-1:0]      r_i, r_j;
   logic              r_rd_v, r_rd_first, r_rd_last;
   logic [ACC_W-1:0]  r_acc;
   logic [PIX_W-1:0]  r_data_last;

   logic              w_start_ok, w_avg, w_win_first, w_win_last;
   logic              w_last_dx, w_last_rd;
   logic [ADDR_W-1:0] w_dw, w_dh, w_sx, w_sy;
   logic [ACC_W-1:0]  w_sum;
   logic [PIX_W-1:0]  w_wdata;

   assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_avg       = (r_mode == M_AVG);
   // Non-average modes treat every read as a complete one-sample window.
   assign w_win_first = !w_avg || (r_i == '0 && r_j == '0);
   assign w_win_last  = !w_avg || (&r_i && &r_j);
   assign w_last_dx   = (r_dx == w_dw - 1'b1);
   assign w_last_rd   = w_win_last && w_last_dx && (r_dy == w_dh - 1'b1);

   // Destination size and source coordinate for the current read.
   always_comb begin
      w_dw = W_CP;
      w_dh = H_CP;
      w_sx = r_dx;
      w_sy = r_dy;
      case (r_mode)
         M_UP: begin
            w_dw = W_UP;
            w_dh = H_UP;
            w_sx = r_dx >> L;
            w_sy = r_dy >> L;
         end
         M_DEC: begin
            w_dw = W_DN;
            w_dh = H_DN;
            w_sx = r_dx << L;
            w_sy = r_dy << L;
         end
         M_COPY: begin
            w_dw = W_CP;
            w_dh = H_CP;
         end
         default: begin
            w_dw = W_DN;
            w_dh = H_DN;
            w_sx = (r_dx << L) + ADDR_W'(r_j);
            w_sy = (r_dy << L) + ADDR_W'(r_i);
         end
      endcase
   end

   assign rom_addr = w_sy * ADDR_W'(SRC_W) + w_sx;
   assign dst_w    = w_dw[9:0];
   assign dst_h    = w_dh[9:0];

   // The ROM output register is the single pipeline stage, so write data is
   // formed from rom_data in the cycle it arrives and held once the strobe drops.
   assign w_sum      = r_rd_first ? ACC_W'(rom_data) : r_acc + ACC_W'(rom_data);
   assign w_wdata    = w_avg ? PIX_W'(w_sum >> (2*L)) : rom_data;
   assign ram_wren   = r_rd_v && r_rd_last;
   assign ram_data   = ram_wren ? w_wdata : r_data_last;
   assign ram_wraddr = r_wraddr;
   assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done       = (r_state == S_DONE);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last_rd) w_next = S_DRAIN;
         S_DRAIN: if (ram_wren) w_next = S_DONE;
         default: w_next = start ? S_RUN : S_IDLE;
      endcase
   end

   // Mode latch and destination / window counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mode <= M_COPY;
         r_dx   <= '0;
         r_dy   <= '0;
         r_didx <= '0;
         r_i    <= '0;
         r_j    <= '0;
      end else if (w_start_ok) begin
         r_mode <= mode;
         r_dx   <= '0;
         r_dy   <= '0;
         r_didx <= '0;
         r_i    <= '0;
         r_j    <= '0;
      end else if (r_state == S_RUN) begin
         if (!w_win_last) begin
            if (&r_j) begin
               r_j <= '0;
               r_i <= r_i + 1'b1;
            end else begin
               r_j <= r_j + 1'b1;
            end
         end else begin
            r_i    <= '0;
            r_j    <= '0;
            r_didx <= r_didx + 1'b1;
            if (w_last_dx) begin
               r_dx <= '0;
               r_dy <= r_dy + 1'b1;
            end else begin
               r_dx <= r_dx + 1'b1;
            end
         end
      end
   end

   // Read tags travel alongside the ROM latency to frame the write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_v     <= 1'b0;
         r_rd_first <= 1'b0;
         r_rd_last  <= 1'b0;
         r_wraddr   <= '0;
      end else begin
         r_rd_v     <= (r_state == S_RUN);
         r_rd_first <= w_win_first;
         r_rd_last  <= w_win_last;
         if (r_state == S_RUN && w_win_last) r_wraddr <= r_didx;
      end
   end

   // Window accumulator and held copy of the last written pixel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc       <= '0;
         r_data_last <= '0;
      end else begin
         if (r_rd_v)   r_acc       <= w_sum;
         if (ram_wren) r_data_last <= w_wdata;
      end
   end

endmodule
